// File: rtl/lc3b_control.sv
// Moore control FSM for the LC-3b mp0 datapath: fetch/decode/execute for ADD/AND/NOT/LDR/STR/BR.
// Latency: 5 cycles ALU and BR not-taken, 6 BR taken, 7 LDR/STR, plus 1 per extra memory wait cycle.
// Backpressure: FETCH2/LDR1/STR2 hold with mem_read/mem_write high until mem_resp. PERF_CNT_EN adds the perf_instret counter.
module lc3b_control #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           opcode,
    input  logic                 branch_enable,
    input  logic                 mem_resp,
    output logic                 pcmux_sel,
    output logic                 storemux_sel,
    output logic                 marmux_sel,
    output logic                 mdrmux_sel,
    output logic                 regfilemux_sel,
    output logic                 alumux_sel,
    output logic                 load_pc,
    output logic                 load_ir,
    output logic                 load_mar,
    output logic                 load_mdr,
    output logic                 load_regfile,
    output logic                 load_cc,
    output logic [2:0]           aluop,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [1:0]           mem_byte_enable,
    output logic [CNT_WIDTH-1:0] perf_instret
);

    localparam logic [3:0] OP_BR  = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_LDR = 4'h6;
    localparam logic [3:0] OP_STR = 4'h7;
    localparam logic [3:0] OP_NOT = 4'h9;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_AND  = 3'd1;
    localparam logic [2:0] ALU_NOT  = 3'd2;
    localparam logic [2:0] ALU_PASS = 3'd3;

    typedef enum logic [3:0] {
        FETCH1, FETCH2, FETCH3, DECODE,
        S_ADD, S_AND, S_NOT,
        BR, BR_TAKEN,
        CALC_ADDR, LDR1, LDR2, STR1, STR2
    } state_t;

    state_t state, next_state;

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH1;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            FETCH1:    next_state = FETCH2;
            FETCH2:    next_state = mem_resp ? FETCH3 : FETCH2;
            FETCH3:    next_state = DECODE;
            DECODE: begin
                case (opcode)
                    OP_ADD:         next_state = S_ADD;
                    OP_AND:         next_state = S_AND;
                    OP_NOT:         next_state = S_NOT;
                    OP_LDR, OP_STR: next_state = CALC_ADDR;
                    OP_BR:          next_state = BR;
                    default:        next_state = FETCH1;
                endcase
            end
            S_ADD, S_AND, S_NOT: next_state = FETCH1;
            BR:        next_state = branch_enable ? BR_TAKEN : FETCH1;
            BR_TAKEN:  next_state = FETCH1;
            CALC_ADDR: next_state = (opcode == OP_LDR) ? LDR1 : STR1;
            LDR1:      next_state = mem_resp ? LDR2 : LDR1;
            LDR2:      next_state = FETCH1;
            STR1:      next_state = STR2;
            STR2:      next_state = mem_resp ? FETCH1 : STR2;
            default:   next_state = FETCH1;
        endcase
    end

    // Outputs depend on state only; reset gating drops any pending memory request immediately.
    always_comb begin
        pcmux_sel      = 1'b0;
        storemux_sel   = 1'b0;
        marmux_sel     = 1'b0;
        mdrmux_sel     = 1'b0;
        regfilemux_sel = 1'b0;
        alumux_sel     = 1'b0;
        load_pc        = 1'b0;
        load_ir        = 1'b0;
        load_mar       = 1'b0;
        load_mdr       = 1'b0;
        load_regfile   = 1'b0;
        load_cc        = 1'b0;
        aluop          = ALU_ADD;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        if (!rst) begin
            case (state)
                FETCH1: begin
                    marmux_sel = 1'b1;
                    load_mar   = 1'b1;
                    load_pc    = 1'b1;
                end
                FETCH2, LDR1: begin
                    mem_read   = 1'b1;
                    mdrmux_sel = 1'b1;
                    load_mdr   = 1'b1;
                end
                FETCH3: load_ir = 1'b1;
                S_ADD, S_AND, S_NOT: begin
                    aluop        = (state == S_AND) ? ALU_AND :
                                   (state == S_NOT) ? ALU_NOT : ALU_ADD;
                    load_regfile = 1'b1;
                    load_cc      = 1'b1;
                end
                BR_TAKEN: begin
                    pcmux_sel = 1'b1;
                    load_pc   = 1'b1;
                end
                CALC_ADDR: begin
                    alumux_sel = 1'b1;
                    load_mar   = 1'b1;
                end
                LDR2: begin
                    regfilemux_sel = 1'b1;
                    load_regfile   = 1'b1;
                    load_cc        = 1'b1;
                end
                STR1: begin
                    storemux_sel = 1'b1;
                    aluop        = ALU_PASS;
                    load_mdr     = 1'b1;
                end
                STR2:    mem_write = 1'b1;
                default: ;
            endcase
        end
    end

    assign mem_byte_enable = 2'b11;

`ifdef PERF_CNT_EN
    logic [CNT_WIDTH-1:0] instret_q;

    // Every path back into FETCH1 leaves a terminal state, so that edge is one retirement.
    always_ff @(posedge clk) begin
        if (rst)
            instret_q <= '0;
        else if (state != FETCH1 && next_state == FETCH1)
            instret_q <= instret_q + CNT_WIDTH'(1);
    end

    assign perf_instret = instret_q;
`else
    assign perf_instret = '0;
`endif

endmodule

// File: tb/tb_lc3b_control.sv
// Bench for lc3b_control: per-instruction expected control traces built from the state-by-state behaviour,
// driven with randomized waits, opcodes and don't-care inputs; PERF_CNT_EN selects the counter expectation.
module tb_lc3b_control;

    localparam int CW = 4;

    localparam logic [3:0] OP_BR  = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_LDR = 4'h6;
    localparam logic [3:0] OP_STR = 4'h7;
    localparam logic [3:0] OP_NOT = 4'h9;
    localparam logic [3:0] OP_UNS = 4'hD;

    // {byte_en, pcmux,storemux,marmux,mdrmux,regfilemux,alumux, ld_pc,ld_ir,ld_mar,ld_mdr,ld_rf,ld_cc, aluop, rd,wr}
    localparam logic [18:0] V_RST  = {2'b11, 6'b000000, 6'b000000, 3'd0, 2'b00};
    localparam logic [18:0] V_F1   = {2'b11, 6'b001000, 6'b101000, 3'd0, 2'b00};
    localparam logic [18:0] V_F2   = {2'b11, 6'b000100, 6'b000100, 3'd0, 2'b10};
    localparam logic [18:0] V_F3   = {2'b11, 6'b000000, 6'b010000, 3'd0, 2'b00};
    localparam logic [18:0] V_IDLE = {2'b11, 6'b000000, 6'b000000, 3'd0, 2'b00};
    localparam logic [18:0] V_ADD  = {2'b11, 6'b000000, 6'b000011, 3'd0, 2'b00};
    localparam logic [18:0] V_AND  = {2'b11, 6'b000000, 6'b000011, 3'd1, 2'b00};
    localparam logic [18:0] V_NOT  = {2'b11, 6'b000000, 6'b000011, 3'd2, 2'b00};
    localparam logic [18:0] V_BRT  = {2'b11, 6'b100000, 6'b100000, 3'd0, 2'b00};
    localparam logic [18:0] V_CALC = {2'b11, 6'b000001, 6'b001000, 3'd0, 2'b00};
    localparam logic [18:0] V_LDR2 = {2'b11, 6'b000010, 6'b000011, 3'd0, 2'b00};
    localparam logic [18:0] V_STR1 = {2'b11, 6'b010000, 6'b000100, 3'd3, 2'b00};
    localparam logic [18:0] V_STR2 = {2'b11, 6'b000000, 6'b000000, 3'd0, 2'b01};

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    opcode;
    logic          branch_enable;
    logic          mem_resp;
    logic          pcmux_sel, storemux_sel, marmux_sel, mdrmux_sel, regfilemux_sel, alumux_sel;
    logic          load_pc, load_ir, load_mar, load_mdr, load_regfile, load_cc;
    logic [2:0]    aluop;
    logic          mem_read, mem_write;
    logic [1:0]    mem_byte_enable;
    logic [CW-1:0] perf_instret;

    always #5 clk = ~clk;

    lc3b_control #(.CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .opcode         (opcode),
        .branch_enable  (branch_enable),
        .mem_resp       (mem_resp),
        .pcmux_sel      (pcmux_sel),
        .storemux_sel   (storemux_sel),
        .marmux_sel     (marmux_sel),
        .mdrmux_sel     (mdrmux_sel),
        .regfilemux_sel (regfilemux_sel),
        .alumux_sel     (alumux_sel),
        .load_pc        (load_pc),
        .load_ir        (load_ir),
        .load_mar       (load_mar),
        .load_mdr       (load_mdr),
        .load_regfile   (load_regfile),
        .load_cc        (load_cc),
        .aluop          (aluop),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_byte_enable(mem_byte_enable),
        .perf_instret   (perf_instret)
    );

    typedef struct {
        logic [18:0]   exp;
        logic          resp;
        logic          be;
        logic [3:0]    op;
        bit            chk_perf;
        logic [CW-1:0] perf;
    } ent_t;

    ent_t tr[$];
    int   retired;
    int   nvec;
    int   nfail;

    function automatic logic [CW-1:0] perf_model();
        logic [31:0] r;
        r = retired;
`ifdef PERF_CNT_EN
        return r[CW-1:0];
`else
        return '0;
`endif
    endfunction

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] rop();
        return 4'($urandom_range(0, 15));
    endfunction

    function automatic void push(logic [18:0] e, logic resp, logic be, logic [3:0] op, bit cp);
        ent_t x;
        x.exp      = e;
        x.resp     = resp;
        x.be       = be;
        x.op       = op;
        x.chk_perf = cp;
        x.perf     = perf_model();
        tr.push_back(x);
    endfunction

    // Fetch and decode: wf cycles without mem_resp before the accepting cycle.
    function automatic void build_fetch(logic [3:0] op, int wf);
        push(V_F1, rb(), rb(), rop(), 1'b1);
        for (int i = 0; i < wf; i++) push(V_F2, 1'b0, rb(), rop(), 1'b0);
        push(V_F2, 1'b1, rb(), rop(), 1'b0);
        push(V_F3, rb(), rb(), rop(), 1'b0);
        push(V_IDLE, rb(), rb(), op, 1'b0);
    endfunction

    function automatic void build(logic [3:0] op, logic be, int wf, int wm);
        build_fetch(op, wf);
        case (op)
            OP_ADD: push(V_ADD, rb(), rb(), op, 1'b0);
            OP_AND: push(V_AND, rb(), rb(), op, 1'b0);
            OP_NOT: push(V_NOT, rb(), rb(), op, 1'b0);
            OP_BR: begin
                push(V_IDLE, rb(), be, op, 1'b0);
                if (be) push(V_BRT, rb(), rb(), op, 1'b0);
            end
            OP_LDR: begin
                push(V_CALC, rb(), rb(), op, 1'b0);
                for (int i = 0; i < wm; i++) push(V_F2, 1'b0, rb(), op, 1'b0);
                push(V_F2, 1'b1, rb(), op, 1'b0);
                push(V_LDR2, rb(), rb(), op, 1'b0);
            end
            OP_STR: begin
                push(V_CALC, rb(), rb(), op, 1'b0);
                push(V_STR1, rb(), rb(), op, 1'b0);
                for (int i = 0; i < wm; i++) push(V_STR2, 1'b0, rb(), op, 1'b0);
                push(V_STR2, 1'b1, rb(), op, 1'b0);
            end
            default: ;
        endcase
        retired++;
    endfunction

    task automatic step(input logic r, input logic resp, input logic be, input logic [3:0] op,
                        output logic [18:0] obs, output logic [CW-1:0] perf);
        @(negedge clk);
        rst           = r;
        mem_resp      = resp;
        branch_enable = be;
        opcode        = op;
        #1;
        obs  = {mem_byte_enable, pcmux_sel, storemux_sel, marmux_sel, mdrmux_sel, regfilemux_sel,
                alumux_sel, load_pc, load_ir, load_mar, load_mdr, load_regfile, load_cc, aluop,
                mem_read, mem_write};
        perf = perf_instret;
    endtask

    task automatic test_reset();
        logic [18:0]   obs;
        logic [CW-1:0] perf;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, rb(), rop(), obs, perf);
            nvec++;
            if (obs !== V_RST) begin
                nfail++;
                $display("FAIL reset_outputs cyc%0d: got %b want %b", i, obs, V_RST);
            end
        end
        retired = 0;
    endtask

    task automatic test_fetch_alu();
        logic [18:0]   obs;
        logic [CW-1:0] perf;
        build(OP_ADD, rb(), 4, 0);
        build(OP_AND, rb(), 0, 0);
        build(OP_NOT, rb(), 1, 0);
        build(OP_UNS, rb(), 0, 0);
        while (tr.size() > 0) begin
            ent_t e;
            e = tr.pop_front();
            step(1'b0, e.resp, e.be, e.op, obs, perf);
            nvec++;
            if (obs !== e.exp) begin
                nfail++;
                $display("FAIL fetch_alu op=%h: got %b want %b", e.op, obs, e.exp);
            end
            if (e.chk_perf) begin
                nvec++;
                if (perf !== e.perf) begin
                    nfail++;
                    $display("FAIL fetch_alu_perf: got %0d want %0d", perf, e.perf);
                end
            end
        end
    endtask

    task automatic test_branch();
        logic [18:0]   obs;
        logic [CW-1:0] perf;
        build(OP_BR, 1'b1, 0, 0);
        build(OP_BR, 1'b0, 0, 0);
        build(OP_BR, 1'b1, 2, 0);
        build(OP_BR, 1'b0, 1, 0);
        while (tr.size() > 0) begin
            ent_t e;
            e = tr.pop_front();
            step(1'b0, e.resp, e.be, e.op, obs, perf);
            nvec++;
            if (obs !== e.exp) begin
                nfail++;
                $display("FAIL branch be=%b: got %b want %b", e.be, obs, e.exp);
            end
            if (e.chk_perf) begin
                nvec++;
                if (perf !== e.perf) begin
                    nfail++;
                    $display("FAIL branch_perf: got %0d want %0d", perf, e.perf);
                end
            end
        end
    endtask

    task automatic test_mem_ops();
        logic [18:0]   obs;
        logic [CW-1:0] perf;
        build(OP_STR, rb(), 0, 0);
        build(OP_LDR, rb(), 0, 0);
        build(OP_LDR, rb(), 1, 3);
        build(OP_STR, rb(), 2, 2);
        while (tr.size() > 0) begin
            ent_t e;
            e = tr.pop_front();
            step(1'b0, e.resp, e.be, e.op, obs, perf);
            nvec++;
            if (obs !== e.exp) begin
                nfail++;
                $display("FAIL mem_ops op=%h: got %b want %b", e.op, obs, e.exp);
            end
            if (e.chk_perf) begin
                nvec++;
                if (perf !== e.perf) begin
                    nfail++;
                    $display("FAIL mem_ops_perf: got %0d want %0d", perf, e.perf);
                end
            end
        end
    endtask

    task automatic test_rst_mid_wait();
        logic [18:0]   obs;
        logic [CW-1:0] perf;
        build_fetch(OP_LDR, 0);
        push(V_CALC, rb(), rb(), OP_LDR, 1'b0);
        push(V_F2, 1'b0, rb(), OP_LDR, 1'b0);
        push(V_F2, 1'b0, rb(), OP_LDR, 1'b0);
        while (tr.size() > 0) begin
            ent_t e;
            e = tr.pop_front();
            step(1'b0, e.resp, e.be, e.op, obs, perf);
            nvec++;
            if (obs !== e.exp) begin
                nfail++;
                $display("FAIL rst_wait_pre op=%h: got %b want %b", e.op, obs, e.exp);
            end
        end
        // Reset lands while LDR1 waits, with mem_resp high in the same cycle.
        step(1'b1, 1'b1, rb(), OP_LDR, obs, perf);
        nvec++;
        if (obs !== V_RST) begin
            nfail++;
            $display("FAIL rst_wait_gate: got %b want %b", obs, V_RST);
        end
        retired = 0;
        step(1'b0, rb(), rb(), rop(), obs, perf);
        nvec++;
        if (obs !== V_F1) begin
            nfail++;
            $display("FAIL rst_wait_fetch1: got %b want %b", obs, V_F1);
        end
        nvec++;
        if (perf !== perf_model()) begin
            nfail++;
            $display("FAIL rst_wait_perf: got %0d want %0d", perf, perf_model());
        end
    endtask

    task automatic test_random_wrap();
        logic [18:0]   obs;
        logic [CW-1:0] perf;
        logic [3:0]    ops [7];
        ops = '{OP_ADD, OP_AND, OP_NOT, OP_BR, OP_LDR, OP_STR, OP_UNS};
        for (int i = 0; i < 2; i++) begin
            step(1'b1, rb(), rb(), rop(), obs, perf);
            nvec++;
            if (obs !== V_RST) begin
                nfail++;
                $display("FAIL wrap_reset: got %b want %b", obs, V_RST);
            end
        end
        retired = 0;
        for (int i = 0; i < 17; i++)
            build(ops[$urandom_range(0, 6)], rb(), $urandom_range(0, 2), $urandom_range(0, 2));
        push(V_F1, rb(), rb(), rop(), 1'b1);
        while (tr.size() > 0) begin
            ent_t e;
            e = tr.pop_front();
            step(1'b0, e.resp, e.be, e.op, obs, perf);
            nvec++;
            if (obs !== e.exp) begin
                nfail++;
                $display("FAIL random op=%h: got %b want %b", e.op, obs, e.exp);
            end
            if (e.chk_perf) begin
                nvec++;
                if (perf !== e.perf) begin
                    nfail++;
                    $display("FAIL random_perf: got %0d want %0d", perf, e.perf);
                end
            end
        end
        nvec++;
`ifdef PERF_CNT_EN
        if (perf !== CW'(1)) begin
            nfail++;
            $display("FAIL perf_wrap: got %0d want 1", perf);
        end
`else
        if (perf !== '0) begin
            nfail++;
            $display("FAIL perf_tied: got %0d want 0", perf);
        end
`endif
    endtask

    initial begin
        rst           = 1'b1;
        mem_resp      = 1'b0;
        branch_enable = 1'b0;
        opcode        = 4'h0;
        retired       = 0;
        nvec          = 0;
        nfail         = 0;
        test_reset();
        test_fetch_alu();
        test_branch();
        test_mem_ops();
        test_rst_mid_wait();
        test_random_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
